bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single system bus among the CPU's bus masters: IF-stage bus_if, MEM-stage bus_if, and up to two external masters (DMA, debug). Each master's active-low bus_req_ is sampled and exactly one active-low bus_grnt_ is returned. Grant is held for as long as the owner keeps requesting, so a multi-cycle bus_if access is never preempted. A hold-time watchdog flags owners that monopolise the bus while others wait.

---
 rtl/bus_arbiter_pkg.sv | 27 ++
 rtl/bus_arbiter_if.sv | 23 ++
 rtl/bus_arbiter_pick.sv | 35 +++
 rtl/bus_arbiter.sv | 126 ++++++++++++
 tb/tb_bus_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared bus constants, owner index type and FSM state encoding
package bus_arbiter_pkg;

  localparam int BUS_MASTER_CH = 4;

  typedef logic [1:0] bus_owner_t;

  localparam bus_owner_t BUS_MASTER_0 = 2'd0;  // IF stage
  localparam bus_owner_t BUS_MASTER_1 = 2'd1;  // MEM stage
  localparam bus_owner_t BUS_MASTER_2 = 2'd2;  // DMA
  localparam bus_owner_t BUS_MASTER_3 = 2'd3;  // debug

  // Active-low request/grant levels
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  // One-hot mask (active-high) selecting a single master
  function automatic logic [BUS_MASTER_CH-1:0] owner_mask(input bus_owner_t idx);
    return BUS_MASTER_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant bundle between bus masters and the arbiter
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  // Vectors are always full width; bits at or above N_MASTERS are ignored / held inactive
  logic [BUS_MASTER_CH-1:0] m_req_;
  logic [BUS_MASTER_CH-1:0] m_grnt_;
  bus_owner_t               owner;
  logic                     owner_vld;
  logic                     hold_err;
  bus_owner_t               hold_err_id;

  modport master (
    output m_req_,
    input  m_grnt_, owner, owner_vld, hold_err, hold_err_id
  );

  modport slave (
    input  m_req_,
    output m_grnt_, owner, owner_vld, hold_err, hold_err_id
  );

endinterface

// File: rtl/bus_arbiter_pick.sv
// rtl/bus_arbiter_pick.sv - combinational rotated-priority picker (bus_arb_pick)
module bus_arb_pick
  import bus_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,    // active-high requests
  input  bus_owner_t   start,  // first index searched, must be < N
  output logic         found,
  output bus_owner_t   idx
);

  logic [2*N-1:0] rot;
  logic [2:0]     cand;

  // Scan the request vector rotated so that bit 0 is the start index; first hit wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    rot   = {req, req} >> start;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, start} + 3'(k);
      if (cand >= 3'(N)) begin
        cand = cand - 3'(N);
      end
      if (!found && rot[0]) begin
        found = 1'b1;
        idx   = cand[1:0];
      end
      rot = rot >> 1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with non-preemptive grant and hold watchdog
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int MAX_HOLD  = 64
) (
  input  logic           clk,
  input  logic           reset,
  bus_arbiter_if.slave   bus
);

  localparam int               CW       = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]    HOLD_MAX = CW'(MAX_HOLD);
  localparam bus_owner_t       LAST_IDX = bus_owner_t'(N_MASTERS - 1);

  arb_state_t               state_q, state_d;
  bus_owner_t               owner_q, owner_d;
  bus_owner_t               last_owner_q, last_owner_d;
  logic [CW-1:0]            hold_cnt_q, hold_cnt_d;
  logic                     err_done_q, err_done_d;
  logic                     hold_err_q, hold_err_d;
  bus_owner_t               hold_err_id_q, hold_err_id_d;
  logic [BUS_MASTER_CH-1:0] grnt_q, grnt_d;

  logic [N_MASTERS-1:0]     req;
  logic [BUS_MASTER_CH-1:0] own_mask;
  logic                     owner_req;
  logic                     waiter;
  bus_owner_t               pick_start;
  logic                     pick_found;
  bus_owner_t               pick_idx;

  assign req        = ~bus.m_req_[N_MASTERS-1:0];
  assign own_mask   = owner_mask(owner_q);
  assign owner_req  = |(req & own_mask[N_MASTERS-1:0]);
  assign waiter     = |(req & ~own_mask[N_MASTERS-1:0]);
  assign pick_start = (last_owner_q == LAST_IDX) ? '0 : last_owner_q + 2'd1;

  bus_arb_pick #(.N(N_MASTERS)) u_pick (
    .req   (req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next state: keep the owner while it requests, otherwise hand over or go idle
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    hold_cnt_d    = hold_cnt_q;
    err_done_d    = err_done_q;
    hold_err_d    = 1'b0;
    hold_err_id_d = hold_err_id_q;
    grnt_d        = {BUS_MASTER_CH{DISABLE_}};
    case (state_q)
      ST_IDLE: begin
        hold_cnt_d = '0;
        if (pick_found) begin
          state_d      = ST_OWNED;
          owner_d      = pick_idx;
          last_owner_d = pick_idx;
          err_done_d   = 1'b0;
        end
      end
      ST_OWNED: begin
        if (owner_req) begin
          if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
          // Fires at most once per ownership, on reaching the limit or when the first waiter shows up
          if (hold_cnt_d == HOLD_MAX && waiter && !err_done_q) begin
            hold_err_d    = 1'b1;
            hold_err_id_d = owner_q;
            err_done_d    = 1'b1;
          end
        end else if (pick_found) begin
          owner_d      = pick_idx;
          last_owner_d = pick_idx;
          hold_cnt_d   = '0;
          err_done_d   = 1'b0;
        end else begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d == ST_OWNED) begin
      grnt_d = ~owner_mask(owner_d);
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      last_owner_q  <= LAST_IDX;
      hold_cnt_q    <= '0;
      err_done_q    <= 1'b0;
      hold_err_q    <= 1'b0;
      hold_err_id_q <= '0;
      grnt_q        <= {BUS_MASTER_CH{DISABLE_}};
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      hold_cnt_q    <= hold_cnt_d;
      err_done_q    <= err_done_d;
      hold_err_q    <= hold_err_d;
      hold_err_id_q <= hold_err_id_d;
      grnt_q        <= grnt_d;
    end
  end

  assign bus.m_grnt_     = grnt_q;
  assign bus.owner       = owner_q;
  assign bus.owner_vld   = (state_q == ST_OWNED);
  assign bus.hold_err    = hold_err_q;
  assign bus.hold_err_id = hold_err_id_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter against a behavioural model
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  bus_arbiter_if bus4();
  bus_arbiter_if bus2();

  bus_arbiter #(.N_MASTERS(4), .MAX_HOLD(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  bus_arbiter #(.N_MASTERS(2), .MAX_HOLD(3)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  // own = -1 means nobody holds the bus
  typedef struct packed {
    int own;
    int last;
    int cnt;
    bit flagged;
    bit err;
    int err_id;
  } mdl_t;

  mdl_t m4, m2;

  function automatic mdl_t step(input mdl_t m, input logic [3:0] req_n, input logic rst,
                                input int n, input int maxh);
    mdl_t r;
    bit   want [4];
    bit   others;
    int   cand;
    r = m;
    r.err = 1'b0;
    others = 1'b0;
    if (rst) begin
      r.own = -1; r.last = n - 1; r.cnt = 0; r.flagged = 1'b0; r.err_id = 0;
      return r;
    end
    for (int i = 0; i < 4; i++) want[i] = (i < n) && (req_n[i] == 1'b0);
    if (m.own >= 0 && want[m.own]) begin
      r.cnt = (m.cnt + 1 > maxh) ? maxh : m.cnt + 1;
      for (int i = 0; i < n; i++) if (i != m.own && want[i]) others = 1'b1;
      if (r.cnt == maxh && others && !m.flagged) begin
        r.err = 1'b1; r.err_id = m.own; r.flagged = 1'b1;
      end
    end else begin
      r.own = -1;
      r.cnt = 0;
      for (int k = 1; k <= n; k++) begin
        cand = (m.last + k) % n;
        if (r.own < 0 && want[cand]) begin
          r.own = cand; r.last = cand; r.flagged = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_grnt(input mdl_t m);
    logic [3:0] one;
    one = 4'b0001;
    return (m.own < 0) ? 4'hF : ~(one << m.own);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    m4 <= step(m4, bus4.m_req_, reset, 4, 4);
    m2 <= step(m2, bus2.m_req_, reset, 2, 3);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_grnt4", int'(bus4.m_grnt_), int'(exp_grnt(m4)));
      chk("vld4", int'(bus4.owner_vld), int'(m4.own >= 0));
      if (m4.own >= 0) chk("owner4", int'(bus4.owner), m4.own);
      chk("err4", int'(bus4.hold_err), int'(m4.err));
      chk("err_id4", int'(bus4.hold_err_id), m4.err_id);
      chk("m_grnt2", int'(bus2.m_grnt_), int'(exp_grnt(m2)));
      chk("vld2", int'(bus2.owner_vld), int'(m2.own >= 0));
      if (m2.own >= 0) chk("owner2", int'(bus2.owner), m2.own);
      chk("err2", int'(bus2.hold_err), int'(m2.err));
      chk("err_id2", int'(bus2.hold_err_id), m2.err_id);
    end
  end

  // Directed literal sequences pin the model, then randomized traffic runs against it
  initial begin
    bus4.m_req_ = 4'b1111;
    bus2.m_req_ = 4'b0011;
    reset = 1'b1;
    cyc(); cyc();
    chk_en = 1'b1;
    chk("rst_grnt", int'(bus4.m_grnt_), 15);
    chk("rst_vld", int'(bus4.owner_vld), 0);
    chk("rst_owner", int'(bus4.owner), 0);
    chk("rst_err", int'(bus4.hold_err), 0);
    chk("rst_err_id", int'(bus4.hold_err_id), 0);
    reset = 1'b0;

    bus4.m_req_ = 4'b1110; cyc();
    chk("first_grnt", int'(bus4.m_grnt_), 4'b1110);
    chk("first_owner", int'(bus4.owner), 0);
    chk("first_vld", int'(bus4.owner_vld), 1);
    bus4.m_req_ = 4'b1111; cyc();
    chk("release_grnt", int'(bus4.m_grnt_), 4'b1111);
    chk("release_vld", int'(bus4.owner_vld), 0);

    bus4.m_req_ = 4'b1110; cyc();
    bus4.m_req_ = 4'b0000; cyc();
    chk("hold0", int'(bus4.m_grnt_), 4'b1110);
    bus4.m_req_ = 4'b0001; cyc();
    chk("rr1", int'(bus4.m_grnt_), 4'b1101);
    bus4.m_req_ = 4'b0010; cyc();
    chk("rr2", int'(bus4.m_grnt_), 4'b1011);
    bus4.m_req_ = 4'b0100; cyc();
    chk("rr3", int'(bus4.m_grnt_), 4'b0111);
    bus4.m_req_ = 4'b1000; cyc();
    chk("rr0", int'(bus4.m_grnt_), 4'b1110);

    bus4.m_req_ = 4'b1111; cyc();
    bus4.m_req_ = 4'b1011; cyc();
    chk("own2", int'(bus4.m_grnt_), 4'b1011);
    bus4.m_req_ = 4'b1101; cyc();
    chk("handover1", int'(bus4.m_grnt_), 4'b1101);
    bus4.m_req_ = 4'b1100; cyc();
    chk("no_preempt_a", int'(bus4.m_grnt_), 4'b1101);
    cyc();
    chk("no_preempt_b", int'(bus4.m_grnt_), 4'b1101);

    bus4.m_req_ = 4'b1111; cyc();
    bus4.m_req_ = 4'b1101; cyc();
    bus4.m_req_ = 4'b0101;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("wd_quiet", int'(bus4.hold_err), 0);
    end
    cyc();
    chk("wd_pulse", int'(bus4.hold_err), 1);
    chk("wd_id", int'(bus4.hold_err_id), 1);
    chk("wd_keep", int'(bus4.m_grnt_), 4'b1101);
    cyc();
    chk("wd_once", int'(bus4.hold_err), 0);
    chk("wd_keep2", int'(bus4.m_grnt_), 4'b1101);

    bus4.m_req_ = 4'b1111; cyc();
    bus4.m_req_ = 4'b0111; cyc();
    chk("own3", int'(bus4.m_grnt_), 4'b0111);
    reset = 1'b1; cyc();
    chk("mid_rst", int'(bus4.m_grnt_), 4'b1111);
    reset = 1'b0;
    bus4.m_req_ = 4'b0000; cyc();
    chk("post_rst", int'(bus4.m_grnt_), 4'b1110);
    chk("post_rst_owner", int'(bus4.owner), 0);

    bus2.m_req_ = 4'b0000; cyc();
    chk("n2_g0", int'(bus2.m_grnt_), 4'b1110);
    bus2.m_req_ = 4'b0001; cyc();
    chk("n2_g1", int'(bus2.m_grnt_), 4'b1101);
    bus2.m_req_ = 4'b0010; cyc();
    chk("n2_g0b", int'(bus2.m_grnt_), 4'b1110);
    bus2.m_req_ = 4'b0001; cyc();
    chk("n2_g1b", int'(bus2.m_grnt_), 4'b1101);

    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(5) == 0) bus4.m_req_[b] = ~bus4.m_req_[b];
        if ($urandom_range(5) == 0) bus2.m_req_[b] = ~bus2.m_req_[b];
      end
      reset = ($urandom_range(199) == 0);
      cyc();
    end
    reset = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
